// File: rtl/demux16_deser_pkg.sv
// Shared types and constants for the bit-select link receive-side deserializer.
// Imported by the top module and by the select decoder.
package demux16_deser_pkg;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_SEL_W = 4;

   localparam logic [DEF_WIDTH-1:0] ALL_ONES = {DEF_WIDTH{1'b1}};

   typedef enum logic {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } state_t;

endpackage

// File: rtl/demux_bit_decoder.sv
// Turns a bit index into a one-hot write enable; the structural inverse of the
// bit-select mux. An index beyond WIDTH-1 yields an all-zero enable.
module demux_bit_decoder
   import demux16_deser_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int SEL_W = DEF_SEL_W
) (
   input  logic [SEL_W-1:0] sel,
   input  logic             en,
   output logic [WIDTH-1:0] onehot
);

   always_comb begin
      onehot = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (en && (sel == i[SEL_W-1:0])) begin
            onehot[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/demux16_deser.sv
// Serial-to-parallel frame assembler: steers one addressed bit per handshake into
// a WIDTH-bit frame and offers the frame once full or force-closed by in_last.
module demux16_deser
   import demux16_deser_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int SEL_W = DEF_SEL_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_bit,
   input  logic [SEL_W-1:0] in_sel,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [WIDTH-1:0] out_mask,
   output logic             out_dup
);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] mask_q;
   logic             dup_q;

   logic             accept;
   logic             xfer;
   logic [WIDTH-1:0] wr_en;
   logic [WIDTH-1:0] mask_upd;
   logic             frame_done;

   // wr_en is already gated by accept, so it is zero whenever nothing is taken
   demux_bit_decoder #(
      .WIDTH (WIDTH),
      .SEL_W (SEL_W)
   ) u_dec (
      .sel    (in_sel),
      .en     (accept),
      .onehot (wr_en)
   );

   assign accept     = in_valid & in_ready;
   assign xfer       = out_valid & out_ready;
   assign mask_upd   = mask_q | wr_en;
   assign frame_done = (&mask_upd) | in_last;

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         COLLECT: begin
            in_ready = 1'b1;
            if (accept && frame_done) begin
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_nxt = COLLECT;
            end
         end
         default: state_nxt = COLLECT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= COLLECT;
      end else begin
         state <= state_nxt;
      end
   end

   // Accept and transfer are mutually exclusive: HOLD never raises in_ready
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
         mask_q <= '0;
         dup_q  <= 1'b0;
      end else if (accept) begin
         data_q <= (data_q & ~wr_en) | (wr_en & {WIDTH{in_bit}});
         mask_q <= mask_upd;
         if (|(mask_q & wr_en)) begin
            dup_q <= 1'b1;
         end
      end else if (xfer) begin
         data_q <= '0;
         mask_q <= '0;
         dup_q  <= 1'b0;
      end
   end

   assign out_data = data_q;
   assign out_mask = mask_q;
   assign out_dup  = dup_q;

endmodule

// File: tb/tb_demux16_deser.sv
// Directed and randomized bench for demux16_deser against a per-position
// write-count model of the frame being assembled.
module tb_demux16_deser;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic        in_bit;
   logic [3:0]  in_sel;
   logic        in_last;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic [15:0] out_mask;
   logic        out_dup;

   int n_cmp = 0;
   int n_err = 0;

   // Model: last value and write count per frame position, plus closed flag
   bit mb[16];
   int mc[16];
   bit mclosed;

   demux16_deser #(
      .WIDTH (16),
      .SEL_W (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_bit    (in_bit),
      .in_sel    (in_sel),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_mask  (out_mask),
      .out_dup   (out_dup)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] m_data();
      logic [15:0] w = '0;
      for (int i = 0; i < 16; i++) if (mc[i] > 0 && mb[i]) w[i] = 1'b1;
      return w;
   endfunction

   function automatic logic [15:0] m_mask();
      logic [15:0] w = '0;
      for (int i = 0; i < 16; i++) if (mc[i] > 0) w[i] = 1'b1;
      return w;
   endfunction

   function automatic logic m_dup();
      for (int i = 0; i < 16; i++) if (mc[i] > 1) return 1'b1;
      return 1'b0;
   endfunction

   function automatic int m_filled();
      int n = 0;
      for (int i = 0; i < 16; i++) if (mc[i] > 0) n++;
      return n;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 16; i++) begin
         mb[i] = 1'b0;
         mc[i] = 0;
      end
      mclosed = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one bit, wait (bounded) for in_ready, let one edge take it
   task automatic send(input int sel, input bit b, input bit last);
      int guard = 0;
      in_valid = 1'b1;
      in_sel   = 4'(sel);
      in_bit   = b;
      in_last  = last;
      while (!in_ready && guard < 50) begin
         step();
         guard++;
      end
      check("in_ready_wait", {15'd0, in_ready}, 16'd1);
      step();
      in_valid = 1'b0;
      in_last  = 1'b0;
      mb[sel] = b;
      mc[sel]++;
      mclosed = last || (m_filled() == 16);
      check("out_valid_after_accept", {15'd0, out_valid}, {15'd0, mclosed});
   endtask

   task automatic check_frame(input string tag);
      check({tag, "_valid"}, {15'd0, out_valid}, 16'd1);
      check({tag, "_data"}, out_data, m_data());
      check({tag, "_mask"}, out_mask, m_mask());
      check({tag, "_dup"}, {15'd0, out_dup}, {15'd0, m_dup()});
      check({tag, "_hold_ready"}, {15'd0, in_ready}, 16'd0);
   endtask

   task automatic take_frame(input string tag);
      out_ready = 1'b1;
      step();
      model_clear();
      check({tag, "_post_valid"}, {15'd0, out_valid}, 16'd0);
      check({tag, "_post_ready"}, {15'd0, in_ready}, 16'd1);
      check({tag, "_post_mask"}, out_mask, 16'd0);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_bit    = 1'b0;
      in_sel    = '0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      model_clear();

      #3;
      check("rst_out_valid", {15'd0, out_valid}, 16'd0);
      check("rst_in_ready", {15'd0, in_ready}, 16'd1);
      check("rst_out_data", out_data, 16'd0);
      check("rst_out_mask", out_mask, 16'd0);
      check("rst_out_dup", {15'd0, out_dup}, 16'd0);
      step();
      rst_n = 1'b1;
      step();

      // Ascending frame, bit = sel[0]
      for (int s = 0; s < 16; s++) send(s, s[0], 1'b0);
      check_frame("asc");
      check("asc_const_data", out_data, 16'hAAAA);
      check("asc_const_mask", out_mask, 16'hFFFF);
      take_frame("asc");

      // Descending frame of ones, consumer stalls five cycles
      out_ready = 1'b0;
      for (int s = 15; s >= 0; s--) send(s, 1'b1, 1'b0);
      for (int k = 0; k < 5; k++) begin
         check_frame("stall");
         check("stall_const_data", out_data, 16'hFFFF);
         if (k < 4) step();
      end
      take_frame("stall");

      // Duplicate write overwrites; in_last closes a partial frame
      send(3, 1'b1, 1'b0);
      send(3, 1'b0, 1'b0);
      send(7, 1'b1, 1'b1);
      check_frame("dup");
      check("dup_const_data", out_data, 16'h0080);
      check("dup_const_mask", out_mask, 16'h0088);
      check("dup_const_dup", {15'd0, out_dup}, 16'd1);
      take_frame("dup");

      // in_last on the first bit
      send(9, 1'b1, 1'b1);
      check_frame("single");
      check("single_const_data", out_data, 16'h0200);
      check("single_const_mask", out_mask, 16'h0200);
      take_frame("single");

      // Asynchronous reset mid-frame
      for (int s = 0; s < 8; s++) send(s, 1'b1, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_out_valid", {15'd0, out_valid}, 16'd0);
      check("arst_in_ready", {15'd0, in_ready}, 16'd1);
      check("arst_out_mask", out_mask, 16'd0);
      check("arst_out_data", out_data, 16'd0);
      step();
      rst_n = 1'b1;
      model_clear();
      step();
      for (int s = 0; s < 16; s++) send(s, 1'b0, 1'b0);
      check_frame("after_rst");
      check("after_rst_const_mask", out_mask, 16'hFFFF);
      take_frame("after_rst");

      // Input held during HOLD is not consumed until after the transfer
      out_ready = 1'b0;
      for (int s = 15; s >= 0; s--) send(s, 1'b0, 1'b0);
      in_valid = 1'b1;
      in_sel   = 4'd0;
      in_bit   = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         check_frame("held_in");
      end
      out_ready = 1'b1;
      step();
      model_clear();
      check("held_xfer_valid", {15'd0, out_valid}, 16'd0);
      check("held_xfer_mask", out_mask, 16'd0);
      send(0, 1'b1, 1'b0);
      for (int s = 1; s < 16; s++) send(s, 1'($urandom), 1'b0);
      check_frame("held_next");
      check("held_next_bit0", {15'd0, out_data[0]}, 16'd1);
      take_frame("held_next");

      // Randomized frames with random stalls
      for (int f = 0; f < 25; f++) begin
         int stall;
         out_ready = 1'($urandom);
         while (!mclosed) begin
            send(int'($urandom_range(0, 15)), 1'($urandom), ($urandom_range(0, 9) == 0));
         end
         out_ready = 1'b0;
         stall = int'($urandom_range(0, 3));
         for (int k = 0; k < stall; k++) begin
            check_frame("rnd_hold");
            step();
         end
         check_frame("rnd");
         take_frame("rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
